// File: rtl/ripple_count_monitor.sv
// Samples an asynchronous ripple-counter bus and filters out ripple glitches.
// Each settled value is published once, and the monitor checks that successive
// values step by +1 modulo 2^WIDTH. It counts wraps and step errors.
module ripple_count_monitor #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned ERR_CNT_W     = 8,
  parameter int unsigned WRAP_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      q_in,
  input  logic                  clr,
  output logic [WIDTH-1:0]      count_out,
  output logic                  count_valid,
  output logic                  wrap_pulse,
  output logic                  step_err,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
  output logic                  locked
);

  localparam int unsigned RunW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(STABLE_CYCLES);

  typedef enum logic {StAcquire, StTrack} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] cand_q;
  logic [RunW-1:0]  run_q;
  logic             accept;
  logic [WIDTH-1:0] next_expected;

  // Two-flop synchronizer per bit. No logic between the stages, and clr does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= q_in;
      sync2_q <= sync1_q;
    end
  end

  // Stability filter: tracks the candidate value and how long it has been seen, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= '0;
      run_q  <= '0;
    end else if (clr) begin
      cand_q <= sync2_q;
      run_q  <= '0;
    end else if (sync2_q != cand_q) begin
      cand_q <= sync2_q;
      run_q  <= RunW'(1);
    end else if (run_q < RunMax) begin
      run_q <= run_q + RunW'(1);
    end
  end

  // A settled candidate is published once. The second term blocks a repeat within one stable period.
  always_comb begin
    accept        = (run_q == RunMax) && ((state_q == StAcquire) || (cand_q != count_out));
    next_expected = count_out + WIDTH'(1);
  end

  // Tracking FSM with registered count, pulses and event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAcquire;
      count_out   <= '0;
      count_valid <= 1'b0;
      wrap_pulse  <= 1'b0;
      step_err    <= 1'b0;
      err_cnt     <= '0;
      wrap_cnt    <= '0;
    end else begin
      count_valid <= 1'b0;
      wrap_pulse  <= 1'b0;
      step_err    <= 1'b0;
      if (clr) begin
        state_q   <= StAcquire;
        count_out <= '0;
        err_cnt   <= '0;
        wrap_cnt  <= '0;
      end else if (accept) begin
        count_out   <= cand_q;
        count_valid <= 1'b1;
        state_q     <= StTrack;
        // The first value after acquisition is the baseline and is not checked.
        if (state_q == StTrack) begin
          if (cand_q == next_expected) begin
            if (&count_out) begin
              wrap_pulse <= 1'b1;
              wrap_cnt   <= wrap_cnt + WRAP_CNT_W'(1);
            end
          end else begin
            step_err <= 1'b1;
            if (!(&err_cnt)) begin
              err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
          end
        end
      end
    end
  end

  // Lock status comes straight from the state register.
  assign locked = (state_q == StTrack);

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor. A history-based model is compared every cycle.
module tb_ripple_count_monitor;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr   = 1'b0;
  logic [3:0] q_in  = 4'd0;

  logic [3:0] a_count, b_count;
  logic       a_valid, a_wrap, a_err, a_locked;
  logic       b_valid, b_wrap, b_err, b_locked;
  logic [7:0] a_errc, a_wrapc, b_wrapc;
  logic [1:0] b_errc;

  always #5 clk = ~clk;

  ripple_count_monitor #(
    .WIDTH(4), .STABLE_CYCLES(2), .ERR_CNT_W(8), .WRAP_CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .clr(clr),
    .count_out(a_count), .count_valid(a_valid), .wrap_pulse(a_wrap), .step_err(a_err),
    .err_cnt(a_errc), .wrap_cnt(a_wrapc), .locked(a_locked)
  );

  // Same stimulus, narrow error counter to exercise saturation.
  ripple_count_monitor #(
    .WIDTH(4), .STABLE_CYCLES(2), .ERR_CNT_W(2), .WRAP_CNT_W(8)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .clr(clr),
    .count_out(b_count), .count_valid(b_valid), .wrap_pulse(b_wrap), .step_err(b_err),
    .err_cnt(b_errc), .wrap_cnt(b_wrapc), .locked(b_locked)
  );

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_wrap  = 0;
  int n_err   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of clock-edge samples of q_in. The two leading zeros stand in for the
  // reset synchronizer. A value counts as settled once it is the latest synchronized sample
  // and has been seen at least twice in a row since the last clear/reset boundary.
  int         samp[$];
  int         base_m;
  logic [3:0] m_count;
  bit         m_valid, m_wrap, m_err, m_locked;
  int         m_errc, m_errc2, m_wrapc;

  function automatic void model_reset();
    samp.delete();
    samp.push_back(0);
    samp.push_back(0);
    base_m   = 0;
    m_count  = 4'd0;
    m_valid  = 1'b0;
    m_wrap   = 1'b0;
    m_err    = 1'b0;
    m_locked = 1'b0;
    m_errc   = 0;
    m_errc2  = 0;
    m_wrapc  = 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      int k, v, rl;
      bit acc;
      k  = samp.size();
      rl = 0;
      v  = -1;
      if (k - 3 >= base_m) begin
        v = samp[k-3];
        for (int i = k - 3; i >= base_m; i--) begin
          if (samp[i] == v) rl++;
          else break;
        end
      end
      acc     = (rl >= 2) && (!m_locked || v != int'(m_count));
      m_valid = 1'b0;
      m_wrap  = 1'b0;
      m_err   = 1'b0;
      if (clr) begin
        m_locked = 1'b0;
        m_count  = 4'd0;
        m_errc   = 0;
        m_errc2  = 0;
        m_wrapc  = 0;
        base_m   = k - 1;
      end else if (acc) begin
        if (m_locked) begin
          if (v == (int'(m_count) + 1) % 16) begin
            if (m_count == 4'd15) begin
              m_wrap  = 1'b1;
              m_wrapc = (m_wrapc + 1) % 256;
            end
          end else begin
            m_err = 1'b1;
            if (m_errc < 255) m_errc++;
            if (m_errc2 < 3) m_errc2++;
          end
        end
        m_count  = 4'(v);
        m_valid  = 1'b1;
        m_locked = 1'b1;
      end
      samp.push_back(int'(q_in));
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #1;
    chk("count_out", a_count, m_count);
    chk("count_valid", a_valid, m_valid);
    chk("wrap_pulse", a_wrap, m_wrap);
    chk("step_err", a_err, m_err);
    chk("err_cnt", a_errc, m_errc);
    chk("wrap_cnt", a_wrapc, m_wrapc);
    chk("locked", a_locked, m_locked);
    chk("sat.count_out", b_count, m_count);
    chk("sat.count_valid", b_valid, m_valid);
    chk("sat.wrap_pulse", b_wrap, m_wrap);
    chk("sat.step_err", b_err, m_err);
    chk("sat.err_cnt", b_errc, m_errc2);
    chk("sat.wrap_cnt", b_wrapc, m_wrapc);
    chk("sat.locked", b_locked, m_locked);
    if (a_valid) n_valid++;
    if (a_wrap) n_wrap++;
    if (a_err) n_err++;
  end

  // Drive v from the next falling edge so that n rising edges sample it.
  task automatic hold(input int v, input int n);
    @(negedge clk);
    q_in = 4'(v);
    repeat (n - 1) @(negedge clk);
  endtask

  // Ripple increment: bits settle LSB first, one time unit apart, well before the next rising edge.
  task automatic ripple_step();
    logic [3:0] nxt;
    @(negedge clk);
    #1;
    nxt = q_in + 4'd1;
    for (int b = 0; b < 4; b++) begin
      if (q_in[b] != nxt[b]) begin
        q_in[b] = nxt[b];
        #1;
      end
    end
  endtask

  initial begin
    // Reset held while the input toggles.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      q_in = (i % 2 == 1) ? 4'hA : 4'h5;
    end
    chk("t1.locked", a_locked, 0);
    chk("t1.count_out", a_count, 0);

    // Normal counting 0..15,0,1.
    @(negedge clk);
    q_in    = 4'd0;
    rst_n   = 1'b1;
    n_valid = 0;
    n_wrap  = 0;
    n_err   = 0;
    for (int i = 0; i < 18; i++) hold(i % 16, (i == 17) ? 8 : 4);
    chk("t2.valid_pulses", n_valid, 18);
    chk("t2.wrap_pulses", n_wrap, 1);
    chk("t2.wrap_cnt", a_wrapc, 1);
    chk("t2.err_cnt", a_errc, 0);
    chk("t2.count_out", a_count, 1);
    chk("t2.locked", a_locked, 1);
    chk("t2.err_pulses", n_err, 0);

    // Glitch: baseline 3 after a clear, a one-sample 7, then 4.
    hold(3, 3);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    hold(3, 6);
    chk("t3.baseline", a_count, 3);
    n_valid = 0;
    hold(7, 1);
    hold(4, 8);
    chk("t3.count_out", a_count, 4);
    chk("t3.valid_pulses", n_valid, 1);
    chk("t3.err_pulses", n_err, 0);

    // Skip 4 -> 6 is an error; 6 -> 7 is not.
    hold(6, 8);
    chk("t4.err_cnt", a_errc, 1);
    chk("t4.count_out", a_count, 6);
    chk("t4.err_pulses", n_err, 1);
    hold(7, 8);
    chk("t4.err_cnt_after", a_errc, 1);
    chk("t4.count_out_after", a_count, 7);

    // Five bad steps: the 2-bit counter saturates at 3.
    hold(9, 6);
    hold(11, 6);
    hold(13, 6);
    hold(15, 6);
    hold(1, 8);
    chk("t5.err_cnt", a_errc, 6);
    chk("t5.sat_err_cnt", b_errc, 3);
    // clr lands on the edge where 4 would be accepted.
    n_valid = 0;
    @(negedge clk);
    q_in = 4'd4;
    repeat (4) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t5.no_valid", n_valid, 0);
    chk("t5.clr_count", a_count, 0);
    chk("t5.clr_locked", a_locked, 0);
    chk("t5.clr_err", a_errc, 0);
    chk("t5.clr_sat_err", b_errc, 0);
    hold(4, 8);
    chk("t5.rebase", a_count, 4);
    chk("t5.relocked", a_locked, 1);
    chk("t5.rebase_err", a_errc, 0);
    chk("t5.rebase_valid", n_valid, 1);

    // Reset mid-run after two wraps.
    hold(15, 6);
    hold(0, 6);
    hold(15, 6);
    hold(0, 8);
    chk("t6.wrap_cnt", a_wrapc, 2);
    chk("t6.err_cnt", a_errc, 2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6.rst_count", a_count, 0);
    chk("t6.rst_wrap", a_wrapc, 0);
    chk("t6.rst_err", a_errc, 0);
    chk("t6.rst_locked", a_locked, 0);
    rst_n = 1'b1;
    hold(0, 8);
    chk("t6.relock", a_locked, 1);
    chk("t6.relock_err", a_errc, 0);

    // Emulated ripple counter: 20 increments from 0, each held for four clocks.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    for (int s = 0; s < 20; s++) begin
      ripple_step();
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("rip.count_out", a_count, 4);
    chk("rip.err_cnt", a_errc, 0);
    chk("rip.wrap_cnt", a_wrapc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
